// File: rtl/can_bus_model_pkg.sv
// Shared types and helpers for the CAN bus model: idle-monitor states, fault modes, delay clamp.
package can_bus_model_pkg;
  localparam int EDGE_CNT_W = 16;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} idle_state_e;
  typedef enum logic [1:0] {INJ_NONE, INJ_DOM, INJ_REC, INJ_INV} inj_mode_e;

  function automatic int unsigned clamp_dly(input int unsigned dly, input int unsigned max_dly);
    return (dly > max_dly) ? max_dly : dly;
  endfunction
endpackage

// File: rtl/can_delay_line.sv
// Shift register preset to recessive (1) with a selectable tap; sel_i=0 is a pure wire.
module can_delay_line #(
  parameter int MAX_DLY = 15,
  parameter int DLY_W   = $clog2(MAX_DLY+1)
) (
  input  logic             clk_i,
  input  logic             reg_rst_i,
  input  logic             d_i,
  input  logic [DLY_W-1:0] sel_i,
  output logic             q_o
);
  logic [MAX_DLY-1:0] sr;
  logic [MAX_DLY:0]   taps;

  // taps[i] is d_i delayed by i cycles
  assign taps = {sr, d_i};

  always_ff @(posedge clk_i) begin
    if (reg_rst_i) sr <= '1;
    else           sr <= taps[MAX_DLY-1:0];
  end

  assign q_o = (int'(sel_i) > MAX_DLY) ? taps[MAX_DLY] : taps[sel_i];
endmodule

// File: rtl/can_bus_model.sv
// Wired-AND CAN bus with per-node TX/RX propagation delay, idle/SOF/edge monitor.
// Optional fault injection on the bus point when CAN_BUS_FAULT_INJ_EN is defined.
module can_bus_model
  import can_bus_model_pkg::*;
#(
  parameter int N_NODES   = 3,
  parameter int MAX_DLY   = 15,
  parameter int DLY_W     = $clog2(MAX_DLY+1),
  parameter int IDLE_BITS = 11,
  parameter int BT_W      = 16
) (
  input  logic                     clk_i,
  input  logic                     reg_rst_i,
  input  logic [N_NODES-1:0]       tx_i,
  input  logic                     cfg_load_i,
  input  logic [N_NODES*DLY_W-1:0] node_dly_i,
  input  logic [BT_W-1:0]          bit_cycles_i,
`ifdef CAN_BUS_FAULT_INJ_EN
  input  logic [1:0]               inj_mode_i,
  input  logic                     inj_start_i,
  input  logic [15:0]              inj_len_i,
  output logic                     inj_active_o,
`endif
  output logic [N_NODES-1:0]       rx_o,
  output logic                     bus_o,
  output logic                     bus_idle_o,
  output logic                     sof_o,
  output logic [EDGE_CNT_W-1:0]    edge_cnt_o
);
  localparam int CNT_W = BT_W + 4;

  logic [N_NODES-1:0][DLY_W-1:0] dly_q;
  logic [N_NODES-1:0]            tx_dly;
  logic                          bus_and, bus_d, bus_q;

  always_ff @(posedge clk_i) begin
    if (reg_rst_i) dly_q <= '0;
    else if (cfg_load_i)
      for (int k = 0; k < N_NODES; k++)
        dly_q[k] <= DLY_W'(clamp_dly(32'(node_dly_i[k*DLY_W +: DLY_W]), MAX_DLY));
  end

  for (genvar k = 0; k < N_NODES; k++) begin : g_node
    can_delay_line #(.MAX_DLY(MAX_DLY), .DLY_W(DLY_W)) u_tx (
      .clk_i, .reg_rst_i, .d_i(tx_i[k]), .sel_i(dly_q[k]), .q_o(tx_dly[k]));
    can_delay_line #(.MAX_DLY(MAX_DLY), .DLY_W(DLY_W)) u_rx (
      .clk_i, .reg_rst_i, .d_i(bus_q), .sel_i(dly_q[k]), .q_o(rx_o[k]));
  end

  assign bus_and = &tx_dly;

`ifdef CAN_BUS_FAULT_INJ_EN
  logic [15:0] inj_cd_q;
  inj_mode_e   inj_mode_q, inj_mode_eff;
  logic        inj_act_q, inj_start_ok, inj_on;

  // A start acts on the same cycle it is sampled so bus_o shows it one cycle later
  assign inj_start_ok = inj_start_i && (inj_mode_i != 2'd0) && (inj_len_i != 16'd0);
  assign inj_on       = inj_start_ok || (inj_cd_q != 16'd0);
  assign inj_mode_eff = inj_start_ok ? inj_mode_e'(inj_mode_i) : inj_mode_q;

  always_comb begin
    bus_d = bus_and;
    if (inj_on) begin
      case (inj_mode_eff)
        INJ_DOM: bus_d = 1'b0;
        INJ_REC: bus_d = 1'b1;
        INJ_INV: bus_d = ~bus_and;
        default: bus_d = bus_and;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reg_rst_i) begin
      inj_cd_q   <= '0;
      inj_mode_q <= INJ_NONE;
      inj_act_q  <= 1'b0;
    end else begin
      inj_act_q <= inj_on;
      if (inj_start_ok) begin
        inj_cd_q   <= inj_len_i - 16'd1;
        inj_mode_q <= inj_mode_e'(inj_mode_i);
      end else if (inj_cd_q != 16'd0) begin
        inj_cd_q <= inj_cd_q - 16'd1;
      end
    end
  end

  assign inj_active_o = inj_act_q;
`else
  assign bus_d = bus_and;
`endif

  // Idle monitor runs on the value entering bus_q so its flags line up with bus_o
  idle_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc, thr;
  logic                  idle_q, idle_d, sof_q, sof_d;
  logic [EDGE_CNT_W-1:0] edge_q;

  assign thr     = CNT_W'(IDLE_BITS) *
                   CNT_W'((bit_cycles_i == '0) ? BT_W'(1) : bit_cycles_i);
  assign cnt_inc = (cnt_q >= thr) ? thr : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = 1'b0;
    sof_d   = 1'b0;
    case (state_q)
      IDLE: begin
        idle_d = 1'b1;
        if (!bus_d) begin
          state_d = ACTIVE;
          idle_d  = 1'b0;
          sof_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = bus_d ? cnt_inc : '0;
        if (cnt_d >= thr) begin
          state_d = IDLE;
          idle_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reg_rst_i) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      idle_q  <= 1'b0;
      sof_q   <= 1'b0;
      bus_q   <= 1'b1;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      sof_q   <= sof_d;
      bus_q   <= bus_d;
      if (bus_q && !bus_d && (edge_q != '1)) edge_q <= edge_q + EDGE_CNT_W'(1);
    end
  end

  assign bus_o      = bus_q;
  assign bus_idle_o = idle_q;
  assign sof_o      = sof_q;
  assign edge_cnt_o = edge_q;
endmodule

// File: tb/tb_can_bus_model.sv
// Bench for can_bus_model: history-based reference model checked every cycle, plus directed timing checks.
`timescale 1ns/1ps
module tb_can_bus_model;
  localparam int N    = 3;
  localparam int MAXD = 12;               // below the 4-bit field range so clamping is reachable
  localparam int DW   = $clog2(MAXD+1);
  localparam int IB   = 11;
  localparam int BTW  = 16;
  localparam int NC   = 24000;

  logic            clk = 1'b0, rst = 1'b1;
  logic [N-1:0]    tx = '1;
  logic            cfg_load = 1'b0;
  logic [N*DW-1:0] node_dly = '0;
  logic [BTW-1:0]  bit_cycles = '0;
  logic [N-1:0]    rx;
  logic            bus, idle, sof;
  logic [15:0]     edge_cnt;
`ifdef CAN_BUS_FAULT_INJ_EN
  logic [1:0]      inj_mode = '0;
  logic            inj_start = 1'b0;
  logic [15:0]     inj_len = '0;
  logic            inj_active;
`endif

  always #5 clk = ~clk;

  can_bus_model #(.N_NODES(N), .MAX_DLY(MAXD), .DLY_W(DW), .IDLE_BITS(IB), .BT_W(BTW)) dut (
    .clk_i(clk), .reg_rst_i(rst), .tx_i(tx), .cfg_load_i(cfg_load), .node_dly_i(node_dly),
    .bit_cycles_i(bit_cycles),
`ifdef CAN_BUS_FAULT_INJ_EN
    .inj_mode_i(inj_mode), .inj_start_i(inj_start), .inj_len_i(inj_len), .inj_active_o(inj_active),
`endif
    .rx_o(rx), .bus_o(bus), .bus_idle_o(idle), .sof_o(sof), .edge_cnt_o(edge_cnt));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the bus at cycle c is the AND of each node's TX taken d_k cycles
  // earlier; rx_j is the bus taken d_j cycles earlier; anything before reset reads recessive.
  int           cyc = 0, base = 0, run = 0, edge_m = 0, m_thr;
  int           dly_m [N];
  logic [N-1:0] tx_h [NC];
  logic         bus_h [NC];
  logic         m_a, idle_m = 1'b0, model_ok = 1'b0;
  logic [N-1:0] exp_rx;
  logic         exp_bus, exp_idle, exp_sof;
`ifdef CAN_BUS_FAULT_INJ_EN
  int           inj_end = -1;
  logic [1:0]   inj_m = '0;
  logic         exp_inj;
`endif

  function automatic logic tx_at(input int idx, input int k);
    return (idx <= base) ? 1'b1 : tx_h[idx][k];
  endfunction
  function automatic logic bus_at(input int idx);
    return (idx <= base) ? 1'b1 : bus_h[idx];
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (cyc >= NC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NC);
      $fatal(1);
    end
    tx_h[cyc] = tx;
    if (rst) begin
      base = cyc; bus_h[cyc] = 1'b1; run = 0; idle_m = 1'b0; edge_m = 0;
      for (int k = 0; k < N; k++) dly_m[k] = 0;
      exp_rx = '1; exp_bus = 1'b1; exp_idle = 1'b0; exp_sof = 1'b0;
`ifdef CAN_BUS_FAULT_INJ_EN
      inj_end = -1; exp_inj = 1'b0;
`endif
      model_ok = 1'b1;
    end else begin
      m_a = 1'b1;
      for (int k = 0; k < N; k++) m_a &= tx_at(cyc - dly_m[k], k);
`ifdef CAN_BUS_FAULT_INJ_EN
      if (inj_start && inj_mode != 2'd0 && inj_len != 16'd0) begin
        inj_m = inj_mode; inj_end = cyc + int'(inj_len) - 1;
      end
      exp_inj = (cyc <= inj_end);
      if (exp_inj) case (inj_m)
        2'd1: m_a = 1'b0;
        2'd2: m_a = 1'b1;
        2'd3: m_a = ~m_a;
        default: ;
      endcase
`endif
      bus_h[cyc] = m_a;
      m_thr = IB * ((bit_cycles == '0) ? 1 : int'(bit_cycles));
      run = m_a ? run + 1 : 0;
      exp_sof = idle_m && !m_a;
      idle_m = (run >= m_thr);
      if (bus_h[cyc-1] && !m_a && edge_m < 65535) edge_m++;
      if (cfg_load)
        for (int k = 0; k < N; k++)
          dly_m[k] = (int'(node_dly[k*DW +: DW]) > MAXD) ? MAXD : int'(node_dly[k*DW +: DW]);
      for (int j = 0; j < N; j++) exp_rx[j] = bus_at(cyc - dly_m[j]);
      exp_bus = m_a; exp_idle = idle_m;
    end
  end

  always @(negedge clk) if (model_ok) begin
    chk("rx_o", rx, exp_rx);
    chk("bus_o", bus, exp_bus);
    chk("bus_idle_o", idle, exp_idle);
    chk("sof_o", sof, exp_sof);
    chk("edge_cnt_o", edge_cnt, edge_m);
`ifdef CAN_BUS_FAULT_INJ_EN
    chk("inj_active_o", inj_active, exp_inj);
`endif
  end

  // Directed helpers; all inputs change on the falling edge
  int obs_first [6], obs_lows [6], obs_inj, k_idle, e0;

  task automatic do_reset(input int bc);
    rst = 1'b1;
    @(negedge clk);
    bit_cycles = BTW'(bc); tx = '1; cfg_load = 1'b0;
    @(negedge clk);
    chk("rst_rx", rx, 3'b111);
    chk("rst_bus", bus, 1);
    chk("rst_idle", idle, 0);
    chk("rst_sof", sof, 0);
    chk("rst_edge", edge_cnt, 0);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    k_idle = 0;
    do begin @(negedge clk); k_idle++; end while (!idle && k_idle < bound);
  endtask

  task automatic load_dly(input int d0, input int d1, input int d2);
    node_dly = {DW'(d2), DW'(d1), DW'(d0)}; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Drive low windows [s,e] per node (step 0 = first driven cycle) and record, per
  // observed signal, the first step at which it was low and how many steps it was low.
  task automatic run_pattern(input int n, input int s0, input int ee0, input int s1, input int e1,
                             input int s2, input int e2);
    logic [5:0] smp;
    for (int b = 0; b < 6; b++) begin obs_first[b] = 0; obs_lows[b] = 0; end
    obs_inj = 0;
    for (int k = 0; k < n; k++) begin
      tx[0] = !(k >= s0 && k <= ee0);
      tx[1] = !(k >= s1 && k <= e1);
      tx[2] = !(k >= s2 && k <= e2);
`ifdef CAN_BUS_FAULT_INJ_EN
      if (k == 1) inj_start = 1'b0;
`endif
      @(negedge clk);
      smp = {idle, ~sof, rx, bus};
      for (int b = 0; b < 6; b++)
        if (!smp[b]) begin obs_lows[b]++; if (obs_first[b] == 0) obs_first[b] = k + 1; end
`ifdef CAN_BUS_FAULT_INJ_EN
      if (inj_active) obs_inj++;
`endif
    end
    tx = '1;
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < N; j++) tx[j] = ($urandom_range(0, 15) != 0);
      cfg_load = ($urandom_range(0, 63) == 0);
      if (cfg_load) node_dly = (N*DW)'($urandom);
`ifdef CAN_BUS_FAULT_INJ_EN
      inj_start = ($urandom_range(0, 99) == 0);
      inj_mode  = 2'($urandom_range(0, 3));
      inj_len   = 16'($urandom_range(0, 20));
`endif
      @(negedge clk);
    end
    tx = '1; cfg_load = 1'b0;
`ifdef CAN_BUS_FAULT_INJ_EN
    inj_start = 1'b0;
`endif
  endtask

  initial begin
    // bit_cycles=0 behaves as 1: idle after 11 recessive cycles
    do_reset(0);
    wait_idle(100);
    chk("idle_rise_bc0", k_idle, 11);
    rand_traffic(3000);
    load_dly(7, 12, 3);
    rand_traffic(40);
    // reset while traffic and long delays are in flight
    do_reset(200);
    wait_idle(3000);
    chk("idle_rise_bc200", k_idle, 2200);

    // SOF from idle, then a second dominant before idle returns
    run_pattern(3, 0, 0, 1, 0, 1, 0);
    chk("sof_first", obs_first[4], 1);
    chk("sof_count", obs_lows[4], 1);
    chk("idle_drop", obs_first[5], 1);
    chk("sof_bus_first", obs_first[0], 1);
    chk("sof_edge", edge_cnt, 1);
    repeat (50) @(negedge clk);
    run_pattern(5, 0, 0, 1, 0, 1, 0);
    chk("no_sof_count", obs_lows[4], 0);
    chk("second_edge", edge_cnt, 2);

    // per-node delays 2/5/0, one-cycle pulse on node1
    load_dly(2, 5, 0);
    repeat (3) @(negedge clk);
    run_pattern(20, 1, 0, 0, 0, 1, 0);
    chk("d_bus_first", obs_first[0], 6);
    chk("d_rx2_first", obs_first[3], 6);
    chk("d_rx0_first", obs_first[1], 8);
    chk("d_rx1_first", obs_first[2], 11);
    for (int b = 0; b < 4; b++) chk("d_width", obs_lows[b], 1);

    // overlapping dominants merge into one low period and one edge
    load_dly(0, 0, 0);
    e0 = int'(edge_cnt);
    run_pattern(25, 0, 9, 1, 0, 5, 14);
    chk("ovl_first", obs_first[0], 1);
    chk("ovl_lows", obs_lows[0], 15);
    chk("ovl_edges", int'(edge_cnt) - e0, 1);

    // 15 clamps to MAX_DLY=12 -> latency 13
    load_dly(15, 0, 0);
    repeat (2) @(negedge clk);
    run_pattern(20, 0, 0, 1, 0, 1, 0);
    chk("clamp_latency", obs_first[0], 13);

    rand_traffic(3000);

`ifdef CAN_BUS_FAULT_INJ_EN
    load_dly(0, 0, 0);
    wait_idle(3000);
    chk("inj_pre_idle", idle, 1);
    inj_mode = 2'd1; inj_len = 16'd10; inj_start = 1'b1;
    run_pattern(15, 1, 0, 1, 0, 1, 0);
    chk("inj_dom_first", obs_first[0], 1);
    chk("inj_dom_lows", obs_lows[0], 10);
    chk("inj_active_len", obs_inj, 10);
    inj_mode = 2'd3; inj_len = 16'd5; inj_start = 1'b1;
    run_pattern(15, 0, 11, 1, 0, 1, 0);
    chk("inj_inv_first", obs_first[0], 6);
    chk("inj_inv_lows", obs_lows[0], 7);
    rand_traffic(1500);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
